// File: rtl/rf_wb_arbiter_if.sv
// Writeback / scoreboard bundle between the EXU, LSU and IDU requesters and rf_wb_arbiter.
// master: requester side (drives wbN_*, alloc_*, chk_addrN); slave: the arbiter.
// Signals: wb0_* (EXU result), wb1_* (LSU load), alloc_* (IDU pending-write mark),
//          chk_addrN/chk_busyN (hazard queries), rf_* (RegisterFile write port).
interface rf_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  wb0_valid;
    logic                  wb0_ready;
    logic [ADDR_WIDTH-1:0] wb0_addr;
    logic [DATA_WIDTH-1:0] wb0_data;
    logic                  wb1_valid;
    logic                  wb1_ready;
    logic [ADDR_WIDTH-1:0] wb1_addr;
    logic [DATA_WIDTH-1:0] wb1_data;
    logic                  alloc_valid;
    logic                  alloc_ready;
    logic [ADDR_WIDTH-1:0] alloc_addr;
    logic [ADDR_WIDTH-1:0] chk_addr1;
    logic                  chk_busy1;
    logic [ADDR_WIDTH-1:0] chk_addr2;
    logic                  chk_busy2;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    modport slave (
        input  wb0_valid, wb0_addr, wb0_data,
        input  wb1_valid, wb1_addr, wb1_data,
        input  alloc_valid, alloc_addr, chk_addr1, chk_addr2,
        output wb0_ready, wb1_ready, alloc_ready, chk_busy1, chk_busy2,
        output rf_wen, rf_waddr, rf_wdata
    );

    modport master (
        output wb0_valid, wb0_addr, wb0_data,
        output wb1_valid, wb1_addr, wb1_data,
        output alloc_valid, alloc_addr, chk_addr1, chk_addr2,
        input  wb0_ready, wb1_ready, alloc_ready, chk_busy1, chk_busy2,
        input  rf_wen, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Purpose: shares the single RF write port between EXU (port 0) and LSU (port 1), tracks busy registers.
// Latency: 1 cycle from accepted request to rf_wen/rf_waddr/rf_wdata.
// Backpressure: one request accepted every cycle a request is valid; the loser simply waits (ready=0).
// Ports: clk, rst (async, active-high) plus rf_wb_arbiter_if.slave bundle.
// Option: define WB_RR_EN for round-robin on contention; otherwise port 1 (LSU) always wins.
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    rf_wb_arbiter_if.slave    wb
);
    localparam int NREG = 2 ** ADDR_WIDTH;

    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic                  wr_live;
    logic                  alloc_set;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic [NREG-1:0]       busy_q, busy_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
`ifdef WB_RR_EN
    logic                  rr_q, rr_d;
`endif

    // Arbitration: grant1 decides; port 0 takes whatever port 1 does not.
    always_comb begin
`ifdef WB_RR_EN
        // On contention rr_q names the preferred port.
        grant1 = wb.wb1_valid & (~wb.wb0_valid | rr_q);
`else
        grant1 = wb.wb1_valid;
`endif
        grant0   = wb.wb0_valid & ~grant1;
        accept   = grant0 | grant1;
        sel_addr = grant1 ? wb.wb1_addr : wb.wb0_addr;
        sel_data = grant1 ? wb.wb1_data : wb.wb0_data;
        // x0 writes are consumed but never reach the RF or the scoreboard.
        wr_live  = accept && (sel_addr != '0);
    end

    assign wb.wb0_ready = grant0;
    assign wb.wb1_ready = grant1;

    // A register whose pending write retires this cycle can be re-allocated at once.
    assign wb.alloc_ready = (wb.alloc_addr == '0) || !busy_q[wb.alloc_addr] ||
                            (wr_live && (sel_addr == wb.alloc_addr));
    assign alloc_set      = wb.alloc_valid && wb.alloc_ready && (wb.alloc_addr != '0);

    assign wb.chk_busy1 = busy_q[wb.chk_addr1];
    assign wb.chk_busy2 = busy_q[wb.chk_addr2];

    always_comb begin
        busy_d = busy_q;
        // Clear first so a same-edge allocation of the same index wins.
        if (wr_live)   busy_d[sel_addr]      = 1'b0;
        if (alloc_set) busy_d[wb.alloc_addr] = 1'b1;
        busy_d[0] = 1'b0;

        rf_wen_d   = wr_live;
        rf_waddr_d = accept ? sel_addr : rf_waddr_q;
        rf_wdata_d = accept ? sel_data : rf_wdata_q;
    end

`ifdef WB_RR_EN
    always_comb begin
        rr_d = rr_q;
        if (wb.wb0_valid && wb.wb1_valid) rr_d = ~grant1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            busy_q     <= busy_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign wb.rf_wen   = rf_wen_q;
    assign wb.rf_waddr = rf_waddr_q;
    assign wb.rf_wdata = rf_wdata_q;
endmodule
